// File: rtl/fpu_issue_unit.sv
// Issue unit feeding FP commands from the core to the coprocessor port, one per clock.
// Define FPU_ISSUE_PERF_EN to add the issued_cnt/stall_cnt performance counters.
module fpu_issue_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_is_load,
    input  logic [5:0]  cmd_opcode,
    input  logic [4:0]  cmd_rs,
    input  logic [4:0]  cmd_rt,
    input  logic [4:0]  cmd_rd,
    input  logic [31:0] cmd_data,
    input  logic        cache_done,
    output logic [5:0]  opcode,
    output logic [4:0]  addr_reg_in1,
    output logic [4:0]  addr_reg_in2,
    output logic [4:0]  addr_destination,
    output logic [4:0]  write_address,
    output logic [31:0] inputdata_float,
    output logic        write_data_enable,
    input  logic [31:0] outdata_float,
    output logic        st_valid,
    input  logic        st_ready,
    output logic [31:0] st_data,
    output logic        illegal,
    output logic        busy
`ifdef FPU_ISSUE_PERF_EN
    ,
    output logic [31:0] issued_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [5:0] OpNop = 6'b000000;
    localparam logic [5:0] OpSw  = 6'b001011;

    typedef struct packed {
        logic        isLoad;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        ST_CAP  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    function automatic logic isLegal(input cmd_t c);
        if (c.isLoad) return 1'b1;
        return (c.opcode == OpSw) || ((c.opcode[5:3] == 3'b110) && (c.opcode[2:0] != 3'b111));
    endfunction

    state_t      state_q, state_d;
    cmd_t        fifoMem_q [DEPTH];
    logic [AW:0] wrPtr_q, rdPtr_q, fillCount;
    logic [AW-1:0] nextIdx;
    logic        empty, full, hasNext, push, pop;
    cmd_t        headCmd, nextCmd, issueCmd, newCmd;
    logic        issueEn;

    logic [5:0]  opcode_q, opcode_d;
    logic [4:0]  rs_q, rs_d, rt_q, rt_d, rdDst_q, rdDst_d, wrAddr_q, wrAddr_d;
    logic [31:0] wrData_q, wrData_d, stData_q, stData_d;
    logic        wde_q, wde_d, stValid_q, stValid_d, illegal_q, illegal_d;

    assign fillCount = wrPtr_q - rdPtr_q;
    assign empty     = (wrPtr_q == rdPtr_q);
    assign full      = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign hasNext   = (fillCount > (AW+1)'(1));
    assign nextIdx   = rdPtr_q[AW-1:0] + AW'(1);
    assign headCmd   = fifoMem_q[rdPtr_q[AW-1:0]];
    assign nextCmd   = fifoMem_q[nextIdx];
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign newCmd    = '{isLoad: cmd_is_load, opcode: cmd_opcode, rs: cmd_rs, rt: cmd_rt,
                         rd: cmd_rd, data: cmd_data};

    always_ff @(posedge clk) begin
        if (push) fifoMem_q[wrPtr_q[AW-1:0]] <= newCmd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + (AW+1)'(1);
            if (pop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
        end
    end

    // A command only counts as taken on an edge where cache_done is low; otherwise it is re-offered.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        issueEn   = 1'b0;
        issueCmd  = headCmd;
        illegal_d = 1'b0;
        stValid_d = stValid_q;
        stData_d  = stData_q;
        unique case (state_q)
            IDLE: begin
                if (!empty && !cache_done) begin
                    if (isLegal(headCmd)) begin
                        issueEn = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        pop       = 1'b1;
                        illegal_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (cache_done) begin
                    state_d = IDLE;
                end else begin
                    pop = 1'b1;
                    if (!headCmd.isLoad && headCmd.opcode == OpSw) begin
                        state_d = ST_CAP;
                    end else if (hasNext && isLegal(nextCmd)) begin
                        issueEn  = 1'b1;
                        issueCmd = nextCmd;
                        state_d  = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ST_CAP: begin
                if (!cache_done) begin
                    stData_d  = outdata_float;
                    stValid_d = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (st_ready) begin
                    stValid_d = 1'b0;
                    if (!empty && !cache_done && isLegal(headCmd)) begin
                        issueEn = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Loads travel on the write port with a NOP opcode; everything else uses the register-address fields.
    always_comb begin
        opcode_d = OpNop;
        rs_d     = '0;
        rt_d     = '0;
        rdDst_d  = '0;
        wrAddr_d = '0;
        wrData_d = '0;
        wde_d    = 1'b0;
        if (issueEn) begin
            if (issueCmd.isLoad) begin
                wde_d    = 1'b1;
                wrAddr_d = issueCmd.rd;
                wrData_d = issueCmd.data;
            end else begin
                opcode_d = issueCmd.opcode;
                rs_d     = issueCmd.rs;
                rt_d     = issueCmd.rt;
                rdDst_d  = issueCmd.rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            opcode_q  <= OpNop;
            rs_q      <= '0;
            rt_q      <= '0;
            rdDst_q   <= '0;
            wrAddr_q  <= '0;
            wrData_q  <= '0;
            wde_q     <= 1'b0;
            stValid_q <= 1'b0;
            stData_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rdDst_q   <= rdDst_d;
            wrAddr_q  <= wrAddr_d;
            wrData_q  <= wrData_d;
            wde_q     <= wde_d;
            stValid_q <= stValid_d;
            stData_q  <= stData_d;
            illegal_q <= illegal_d;
        end
    end

    assign opcode            = opcode_q;
    assign addr_reg_in1      = rs_q;
    assign addr_reg_in2      = rt_q;
    assign addr_destination  = rdDst_q;
    assign write_address     = wrAddr_q;
    assign inputdata_float   = wrData_q;
    assign write_data_enable = wde_q;
    assign st_valid          = stValid_q;
    assign st_data           = stData_q;
    assign illegal           = illegal_q;
    assign busy              = !empty || (state_q != IDLE);

`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] issuedCnt_q, stallCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issuedCnt_q <= '0;
            stallCnt_q  <= '0;
        end else begin
            if (state_q == ISSUE && pop) issuedCnt_q <= issuedCnt_q + 32'd1;
            if (!empty && cache_done)    stallCnt_q  <= stallCnt_q + 32'd1;
        end
    end

    assign issued_cnt = issuedCnt_q;
    assign stall_cnt  = stallCnt_q;
`endif

endmodule

// File: tb/tb_fpu_issue_unit.sv
// Directed self-checking bench for fpu_issue_unit with a small coprocessor stand-in.
// Build with FPU_ISSUE_PERF_EN defined to also connect the performance counter ports.
module tb_fpu_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_is_load;
    logic [5:0]  cmd_opcode;
    logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
    logic [31:0] cmd_data;
    logic        cache_done;
    logic [5:0]  opcode;
    logic [4:0]  addr_reg_in1, addr_reg_in2, addr_destination, write_address;
    logic [31:0] inputdata_float, outdata_float, st_data;
    logic        write_data_enable, st_valid, st_ready, illegal, busy;
`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] issued_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] fpRegs [32];
    logic [31:0] outdataReg = '0;
    logic [4:0]  wrLog [64];
    int wrLogN = 0, wdeCount = 0, mulCount = 0, badOpCount = 0;

    fpu_issue_unit #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_load(cmd_is_load),
        .cmd_opcode(cmd_opcode), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_data(cmd_data), .cache_done(cache_done),
        .opcode(opcode), .addr_reg_in1(addr_reg_in1), .addr_reg_in2(addr_reg_in2),
        .addr_destination(addr_destination), .write_address(write_address),
        .inputdata_float(inputdata_float), .write_data_enable(write_data_enable),
        .outdata_float(outdata_float), .st_valid(st_valid), .st_ready(st_ready),
        .st_data(st_data), .illegal(illegal), .busy(busy)
`ifdef FPU_ISSUE_PERF_EN
        , .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign outdata_float = outdataReg;

    function automatic real toReal(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:0] == 31'd0) return 0.0;
        e = {3'b000, b[30:23]} + 11'd896;
        return $bitstoreal({b[31], e, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] toSingle(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Coprocessor stand-in: it only acts on edges where cache_done is low.
    always @(posedge clk) begin
        if (!cache_done) begin
            if (write_data_enable) begin
                fpRegs[write_address] <= inputdata_float;
                wrLog[wrLogN[5:0]] = write_address;
                wrLogN = wrLogN + 1;
                wdeCount = wdeCount + 1;
            end
            if (opcode == 6'b110000)
                fpRegs[addr_destination] <= toSingle(toReal(fpRegs[addr_reg_in1]) + toReal(fpRegs[addr_reg_in2]));
            if (opcode == 6'b110010) mulCount = mulCount + 1;
            if (opcode == 6'b111111) badOpCount = badOpCount + 1;
            if (opcode == 6'b001011) outdataReg <= fpRegs[addr_reg_in2];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Presents one command and holds it until accepted; returns on the negedge after the accepting edge.
    task automatic applyStimulus(input logic isLoad, input logic [5:0] op, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] data);
        int n;
        cmd_is_load = isLoad;
        cmd_opcode  = op;
        cmd_rs      = rs;
        cmd_rt      = rt;
        cmd_rd      = rd;
        cmd_data    = data;
        cmd_valid   = 1'b1;
        n = 0;
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) checkOutput("enqueueTimeout", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // sel: 0 = opcode equals op, 1 = st_valid, 2 = not busy, 3 = illegal pulse
    task automatic waitFor(input int sel, input logic [5:0] op, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            case (sel)
                0:       hit = (opcode == op);
                1:       hit = st_valid;
                2:       hit = !busy;
                default: hit = illegal;
            endcase
            if (!hit) @(negedge clk);
        end
        if (!hit) checkOutput(tag, 32'd0, 32'd1);
    endtask

    int wdeBase, logBase, mulBase;

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_is_load = 1'b0; cmd_opcode = '0;
        cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; cmd_data = '0;
        cache_done = 1'b0;
        st_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetStValid", 32'(st_valid), 32'd0);
        checkOutput("resetStData", st_data, 32'd0);
        checkOutput("resetOpcode", 32'(opcode), 32'd0);
        checkOutput("resetWde", 32'(write_data_enable), 32'd0);
        checkOutput("resetIllegal", 32'(illegal), 32'd0);
        checkOutput("resetCmdReady", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // 3.0 + 2.0 stored back through sw
        wdeBase = wdeCount;
        applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 5'd1, 32'h40400000);
        applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 5'd2, 32'h40000000);
        applyStimulus(1'b0, 6'b110000, 5'd1, 5'd2, 5'd3, 32'd0);
        applyStimulus(1'b0, 6'b001011, 5'd0, 5'd3, 5'd0, 32'd0);
        waitFor(0, 6'b001011, "swTimeout");
        checkOutput("swRt", 32'(addr_reg_in2), 32'd3);
        @(negedge clk);
        checkOutput("stValidEarly", 32'(st_valid), 32'd0);
        @(negedge clk);
        checkOutput("stValidLatency", 32'(st_valid), 32'd1);
        checkOutput("stDataAdd", st_data, 32'h40A00000);
        checkOutput("wdePulses", 32'(wdeCount - wdeBase), 32'd2);
        checkOutput("busyHold", 32'(busy), 32'd1);
        st_ready = 1'b1;
        @(negedge clk);
        checkOutput("stValidCleared", 32'(st_valid), 32'd0);
        checkOutput("busyAfterStore", 32'(busy), 32'd0);

        // Five loads against a stalled coprocessor
        wdeBase = wdeCount;
        logBase = wrLogN;
        cache_done = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 5'(4 + i), 32'(100 + i));
        checkOutput("fullNotReady", 32'(cmd_ready), 32'd0);
        checkOutput("noIssueStalled", 32'(wdeCount - wdeBase), 32'd0);
        checkOutput("portNopStalled", 32'(write_data_enable), 32'd0);
        cmd_is_load = 1'b1; cmd_rd = 5'd8; cmd_data = 32'd104; cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("stillNotReady", 32'(cmd_ready), 32'd0);
        cache_done = 1'b0;
        applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 5'd8, 32'd104);
        waitFor(2, 6'b000000, "drainTimeout");
        checkOutput("loadCount", 32'(wrLogN - logBase), 32'd5);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("loadOrder%0d", i), 32'(wrLog[6'(logBase + i)]), 32'(4 + i));
        checkOutput("r8Data", fpRegs[8], 32'd104);

        // mul dropped by a stall rising mid-presentation
        mulBase = mulCount;
        applyStimulus(1'b0, 6'b110010, 5'd1, 5'd2, 5'd9, 32'd0);
        waitFor(0, 6'b110010, "mulTimeout");
        cache_done = 1'b1;
        @(negedge clk);
        checkOutput("mulNopStall", 32'(opcode), 32'd0);
        @(negedge clk);
        cache_done = 1'b0;
        @(negedge clk);
        checkOutput("mulRedriven", 32'(opcode), 32'h32);
        checkOutput("mulRedrivenRd", 32'(addr_destination), 32'd9);
        waitFor(2, 6'b000000, "mulDrainTimeout");
        checkOutput("mulOnce", 32'(mulCount - mulBase), 32'd1);

        // Store held by st_ready with a load queued behind it
        st_ready = 1'b0;
        wdeBase = wdeCount;
        applyStimulus(1'b0, 6'b001011, 5'd0, 5'd3, 5'd0, 32'd0);
        applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 5'd10, 32'h3F800000);
        waitFor(1, 6'b000000, "holdStValidTimeout");
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("holdData%0d", i), st_data, 32'h40A00000);
            checkOutput($sformatf("holdNoIssue%0d", i), 32'(write_data_enable), 32'd0);
            @(negedge clk);
        end
        checkOutput("holdStValid", 32'(st_valid), 32'd1);
        checkOutput("holdNoWrites", 32'(wdeCount - wdeBase), 32'd0);
        st_ready = 1'b1;
        @(negedge clk);
        checkOutput("releaseStValid", 32'(st_valid), 32'd0);
        checkOutput("releaseWde", 32'(write_data_enable), 32'd1);
        checkOutput("releaseAddr", 32'(write_address), 32'd10);
        waitFor(2, 6'b000000, "releaseDrainTimeout");
        checkOutput("r10Data", fpRegs[10], 32'h3F800000);

        // Unsupported opcode followed by a normal load
        applyStimulus(1'b0, 6'b111111, 5'd1, 5'd2, 5'd12, 32'd0);
        applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 5'd11, 32'h41200000);
        waitFor(3, 6'b000000, "illegalTimeout");
        checkOutput("illegalPortNop", 32'(opcode), 32'd0);
        @(negedge clk);
        checkOutput("illegalOnePulse", 32'(illegal), 32'd0);
        waitFor(2, 6'b000000, "illegalDrainTimeout");
        checkOutput("illegalNeverDriven", 32'(badOpCount), 32'd0);
        checkOutput("afterIllegalLoad", fpRegs[11], 32'h41200000);

        // Asynchronous reset while a store waits in ST_HOLD
        st_ready = 1'b0;
        applyStimulus(1'b0, 6'b001011, 5'd0, 5'd3, 5'd0, 32'd0);
        applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 5'd13, 32'd7);
        waitFor(1, 6'b000000, "rstHoldTimeout");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstStValid", 32'(st_valid), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstStData", st_data, 32'd0);
        checkOutput("rstPortWde", 32'(write_data_enable), 32'd0);
        checkOutput("rstPortAddr", 32'(addr_reg_in2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        st_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("postRstIdle", 32'(busy), 32'd0);
        checkOutput("postRstReady", 32'(cmd_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
